tiny_mem_arbiter: RTL and testbench

- Two-port arbiter in front of the unified single-ported tiny_mem_model.
- Shares the memory between the core's instruction-fetch port (read-only) and data port (read/write).
- Sequences each transaction through the memory's valid/ready handshake, including the mandatory idle gap between transactions.
- Data port has priority; fetch is protected by a bounded-starvation counter.

---
 rtl/tiny_mem_arbiter_if.sv | 49 ++++
 rtl/tiny_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_tiny_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the single-ported memory.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface tiny_mem_arbiter_if;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = 4;

  // Instruction-fetch port (read-only)
  logic             i_valid;
  logic [AddrW-1:0] i_addr;
  logic             i_ready;
  logic [DataW-1:0] i_rdata;

  // Data port (read/write)
  logic             d_valid;
  logic             d_we;
  logic [AddrW-1:0] d_addr;
  logic [DataW-1:0] d_wdata;
  logic [StrbW-1:0] d_wstrb;
  logic             d_ready;
  logic [DataW-1:0] d_rdata;

  // Memory side
  logic             mem_valid;
  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic [StrbW-1:0] mem_wstrb;
  logic             mem_ready;
  logic [DataW-1:0] mem_rdata;

  modport slave (
    input  i_valid, i_addr,
    input  d_valid, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_ready, mem_rdata,
    output i_ready, i_rdata,
    output d_ready, d_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output i_valid, i_addr,
    output d_valid, d_we, d_addr, d_wdata, d_wstrb,
    output mem_ready, mem_rdata,
    input  i_ready, i_rdata,
    input  d_ready, d_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/tiny_mem_arbiter.sv
// Two-port arbiter sharing a single-ported memory between instruction fetch and data.
// Data has priority; fetch is forced after MAX_DATA_STREAK consecutive contended data wins.
module tiny_mem_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  tiny_mem_arbiter_if.slave bus,
  output logic              busy,
  output logic              owner
);
  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 32;
  localparam int unsigned StrbW   = 4;
  localparam int unsigned StreakW = 4;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [StreakW-1:0] streak_q,    streak_d;
  logic               owner_q,     owner_d;
  logic               busy_q,      busy_d;
  logic               mem_valid_q, mem_valid_d;
  logic               mem_we_q,    mem_we_d;
  logic [AddrW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DataW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [StrbW-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic               i_ready_q,   i_ready_d;
  logic [DataW-1:0]   i_rdata_q,   i_rdata_d;
  logic               d_ready_q,   d_ready_d;
  logic [DataW-1:0]   d_rdata_q,   d_rdata_d;
  logic               arb_en;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      i_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      i_ready_q   <= i_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state, arbitration and output computation
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    owner_d     = owner_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    i_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ready_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    arb_en      = 1'b0;

    case (state_q)
      ST_IDLE: arb_en = 1'b1;
      ST_ISSUE: begin
        if (bus.mem_ready) begin
          state_d     = ST_DRAIN;
          mem_valid_d = 1'b0;
          if (owner_q) begin
            d_ready_d = 1'b1;
            if (!mem_we_q) d_rdata_d = bus.mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end
        end
      end
      // Hold off until the memory has seen the idle gap and dropped ready
      ST_DRAIN: arb_en = !bus.mem_ready;
      default: state_d = ST_IDLE;
    endcase

    if (arb_en) begin
      if (bus.d_valid && !(bus.i_valid && (streak_q == StreakMax))) begin
        state_d     = ST_ISSUE;
        owner_d     = 1'b1;
        mem_valid_d = 1'b1;
        mem_we_d    = bus.d_we;
        mem_addr_d  = bus.d_addr;
        mem_wdata_d = bus.d_wdata;
        mem_wstrb_d = bus.d_wstrb;
        if (bus.i_valid) begin
          streak_d = (streak_q == StreakMax) ? StreakMax : streak_q + StreakW'(1);
        end else begin
          streak_d = '0;
        end
      end else if (bus.i_valid) begin
        state_d     = ST_ISSUE;
        owner_d     = 1'b0;
        mem_valid_d = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = bus.i_addr;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        streak_d    = '0;
      end else begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = busy_q;
  assign owner         = owner_q;
endmodule

// File: tb/tb_tiny_mem_arbiter.sv
// Bench for tiny_mem_arbiter: memory stub, transaction-timeline reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_tiny_mem_arbiter;
  localparam int unsigned MAX = 4;

  logic clk;
  logic rst_n;
  logic busy;
  logic owner;

  tiny_mem_arbiter_if b ();

  tiny_mem_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b),
    .busy  (busy),
    .owner (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int unsigned k);
    if (k == 4) return 32'hDEADBEEF;
    if (k == 8) return 32'hAAAAAAAA;
    return (32'(k) * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Memory stub: write acks after one cycle of valid, read after two; ready drops once valid is seen low
  logic [31:0] stub_mem [256];
  logic [1:0]  stub_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b.mem_ready <= 1'b0;
      b.mem_rdata <= 32'h0;
      stub_cnt    <= 2'd0;
      for (int k = 0; k < 256; k++) stub_mem[k] <= init_word(k);
    end else if (!b.mem_valid) begin
      b.mem_ready <= 1'b0;
      stub_cnt    <= 2'd0;
    end else if (!b.mem_ready) begin
      if (b.mem_we) begin
        b.mem_ready <= 1'b1;
        for (int k = 0; k < 4; k++)
          if (b.mem_wstrb[k]) stub_mem[b.mem_addr[9:2]][8*k +: 8] <= b.mem_wdata[8*k +: 8];
      end else if (stub_cnt == 2'd1) begin
        b.mem_ready <= 1'b1;
        b.mem_rdata <= stub_mem[b.mem_addr[9:2]];
      end else begin
        stub_cnt <= stub_cnt + 2'd1;
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  // Reference model state
  logic [31:0] ref_mem [256];
  bit          has_txn;
  int          free_edge, g, lat;
  int unsigned streak_m;
  bit          owner_m, t_d, t_we;
  logic [31:0] t_addr, t_wdata, t_rdata, irdata_m, drdata_m;
  logic [3:0]  t_wstrb;

  // Observations used by the directed checks
  bit          mv_prev;
  int          last_rise_n, last_ir_n, last_dr_n, fall_n, min_gap, ir_count, dr_count;
  bit          grant_log [$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    has_txn   = 1'b0;
    free_edge = 0;
    streak_m  = 0;
    owner_m   = 1'b0;
    irdata_m  = 32'h0;
    drdata_m  = 32'h0;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
  endtask

  // Called once per cycle after the negedge; request inputs still hold what the last edge sampled
  task automatic check_cycle();
    logic gnt, e_mv, e_ir, e_dr, e_busy;
    n++;
    if (b.mem_valid && !mv_prev) begin
      grant_log.push_back(owner);
      last_rise_n = n;
      if (fall_n >= 0 && (n - fall_n) < min_gap) min_gap = n - fall_n;
    end
    if (!b.mem_valid && mv_prev) fall_n = n;
    mv_prev = b.mem_valid;
    if (b.i_ready) begin last_ir_n = n; ir_count++; end
    if (b.d_ready) begin last_dr_n = n; dr_count++; end

    gnt = rst_n && (n >= free_edge) && (b.i_valid || b.d_valid);
    if (gnt) begin
      t_d = b.d_valid && !(b.i_valid && streak_m == MAX);
      if (t_d && b.i_valid) streak_m = (streak_m < MAX) ? streak_m + 1 : MAX;
      else                  streak_m = 0;
      t_we    = t_d && b.d_we;
      t_addr  = t_d ? b.d_addr : b.i_addr;
      t_wdata = b.d_wdata;
      t_wstrb = t_d ? b.d_wstrb : 4'b0;
      t_rdata = ref_mem[t_addr[9:2]];
      if (t_we)
        for (int k = 0; k < 4; k++)
          if (t_wstrb[k]) ref_mem[t_addr[9:2]][8*k +: 8] = t_wdata[8*k +: 8];
      g         = n;
      lat       = t_we ? 2 : 3;
      free_edge = n + lat + 2;
      has_txn   = 1'b1;
      owner_m   = t_d;
      chk1("issue_while_mem_ready", b.mem_ready, 1'b0);
    end

    e_mv   = has_txn && (n >= g) && (n < g + lat);
    e_ir   = has_txn && !t_d && (n == g + lat);
    e_dr   = has_txn && t_d && (n == g + lat);
    e_busy = has_txn && (n < free_edge);
    if (e_ir) irdata_m = t_rdata;
    if (e_dr && !t_we) drdata_m = t_rdata;

    chk1("mem_valid", b.mem_valid, e_mv);
    chk1("i_ready", b.i_ready, e_ir);
    chk1("d_ready", b.d_ready, e_dr);
    chk1("busy", busy, e_busy);
    chk1("owner", owner, owner_m);
    chk32("i_rdata", b.i_rdata, irdata_m);
    chk32("d_rdata", b.d_rdata, drdata_m);
    if (e_mv) begin
      chk1("mem_we", b.mem_we, t_we);
      chk32("mem_addr", b.mem_addr, t_addr);
      chk32("mem_wstrb", 32'(b.mem_wstrb), 32'(t_wstrb));
      if (t_we) chk32("mem_wdata", b.mem_wdata, t_wdata);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic wait_pulse(input bit want_d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (want_d ? b.d_ready : b.i_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Requesters honour the contract: hold until ready, update only in the ready-pulse cycle
  task automatic drive_random(input int unsigned pi, input int unsigned pd);
    if (b.i_ready || !b.i_valid) begin
      b.i_valid = ($urandom_range(0, 99) < pi);
      b.i_addr  = $urandom();
    end
    if (b.d_ready || !b.d_valid) begin
      b.d_valid = ($urandom_range(0, 99) < pd);
      b.d_we    = 1'($urandom_range(0, 1));
      b.d_addr  = $urandom();
      b.d_wdata = $urandom();
      b.d_wstrb = 4'($urandom());
    end
  endtask

  int unsigned pi_tab [4] = '{60, 20, 90, 100};
  int unsigned pd_tab [4] = '{60, 90, 30, 100};

  initial begin
    bit ok;
    int wg;
    logic [9:0] exp_order;
    exp_order = 10'b0111101111;  // bit i = grant i went to data: D D D D F D D D D F
    b.i_valid = 1'b0; b.i_addr = 32'h0;
    b.d_valid = 1'b0; b.d_we = 1'b0; b.d_addr = 32'h0; b.d_wdata = 32'h0; b.d_wstrb = 4'h0;
    mv_prev = 1'b0; fall_n = -1; min_gap = 1000; ir_count = 0; dr_count = 0;
    last_rise_n = 0; last_ir_n = 0; last_dr_n = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) step();
    chk1("rst_mem_valid", b.mem_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_mem_addr", b.mem_addr, 32'h0);
    rst_n = 1'b1;

    // Idle: no requests for 20 cycles
    repeat (20) step();
    chk32("idle_no_grants", 32'(grant_log.size()), 32'd0);

    // Single fetch of preloaded word
    dr_count = 0;
    b.i_valid = 1'b1; b.i_addr = 32'h10;
    wait_pulse(1'b0, ok);
    chk1("fetch_done", ok, 1'b1);
    chk32("fetch_latency", 32'(last_ir_n - last_rise_n), 32'd3);
    chk32("fetch_data", b.i_rdata, 32'hDEADBEEF);
    chk32("fetch_no_dready", 32'(dr_count), 32'd0);
    b.i_valid = 1'b0;
    repeat (6) step();

    // Strobed write then read-back of the same word
    b.d_valid = 1'b1; b.d_we = 1'b1; b.d_addr = 32'h20; b.d_wdata = 32'h11223344; b.d_wstrb = 4'b0101;
    wait_pulse(1'b1, ok);
    chk1("write_done", ok, 1'b1);
    wg = last_rise_n;
    chk32("write_latency", 32'(last_dr_n - wg), 32'd2);
    b.d_we = 1'b0; b.d_wdata = 32'h0; b.d_wstrb = 4'h0;
    wait_pulse(1'b1, ok);
    chk1("readback_done", ok, 1'b1);
    chk32("readback_grant_offset", 32'(last_rise_n - wg), 32'd4);
    chk32("readback_latency", 32'(last_dr_n - last_rise_n), 32'd3);
    chk32("readback_data", b.d_rdata, 32'hAA22AA44);
    b.d_valid = 1'b0;
    repeat (6) step();

    // Continuous contention: starvation counter forces every fifth grant to fetch
    grant_log.delete();
    drive_random(100, 100);
    for (int k = 0; k < 400 && grant_log.size() < 10; k++) begin
      step();
      drive_random(100, 100);
    end
    if (grant_log.size() >= 10) begin
      for (int i = 0; i < 10; i++) chk1($sformatf("grant_order_%0d", i), grant_log[i], exp_order[i]);
    end else begin
      chk32("grant_order_count", 32'(grant_log.size()), 32'd10);
    end
    for (int k = 0; k < 60; k++) begin step(); drive_random(0, 0); end

    // Back-to-back fetch reads: idle gap between transactions
    fall_n = -1; min_gap = 1000;
    for (int k = 0; k < 60; k++) begin step(); drive_random(100, 0); end
    for (int k = 0; k < 20; k++) begin step(); drive_random(0, 0); end
    chk32("min_idle_gap", 32'(min_gap), 32'd2);

    // Asynchronous reset in the middle of a read
    b.i_valid = 1'b1; b.i_addr = 32'h10;
    for (int k = 0; k < 20; k++) begin
      step();
      if (b.mem_valid) break;
    end
    step();
    #1 rst_n = 1'b0;
    #1;
    chk1("arst_mem_valid", b.mem_valid, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_owner", owner, 1'b0);
    chk32("arst_mem_addr", b.mem_addr, 32'h0);
    chk32("arst_i_rdata", b.i_rdata, 32'h0);
    model_reset();
    ir_count = 0;
    repeat (3) step();
    chk32("arst_no_pulse", 32'(ir_count), 32'd0);
    rst_n = 1'b1;
    wait_pulse(1'b0, ok);
    chk1("post_reset_fetch_done", ok, 1'b1);
    chk32("post_reset_fetch_data", b.i_rdata, 32'hDEADBEEF);
    b.i_valid = 1'b0;
    repeat (6) step();

    // Randomized traffic under several request densities
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 400; k++) begin
        step();
        drive_random(pi_tab[s], pd_tab[s]);
      end
    end
    for (int k = 0; k < 40; k++) begin step(); drive_random(0, 0); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
